// File: rtl/multicycle_chunk_adder_pkg.sv
// Shared types and helpers for the multicycle chunk adder.
// FSM state encoding (2-bit) and chunk counter width helper.
package multicycle_chunk_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter needs at least one bit even when only one chunk exists.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multicycle_chunk_adder_cla.sv
// carry_lookahead_adder: WIDTH-bit flat carry-lookahead slice.
// Ports: a, b, cin in; sum, cout, group_generate, group_propagate out.
module carry_lookahead_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             group_generate,
    output logic             group_propagate
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic             acc;
    logic             pp;

    // Each carry is a flat sum of generate terms gated by the
    // propagate chain above them, so no carry waits on another.
    always_comb begin
        g               = a & b;
        p               = a ^ b;
        c               = '0;
        c[0]            = cin;
        acc             = 1'b0;
        pp              = 1'b1;
        group_generate  = 1'b0;
        group_propagate = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & cin);
            if (i == WIDTH - 1) begin
                group_generate  = acc;
                group_propagate = pp;
            end
        end
        sum  = p ^ c[WIDTH-1:0];
        cout = c[WIDTH];
    end

endmodule

// File: rtl/multicycle_chunk_adder.sv
// Adds two NUM_CHUNKS*CHUNK_WIDTH operands one chunk per cycle through
// a single lookahead slice, rippling the carry across cycles.
// Ports: clk, rst_n, in_valid/in_ready, x, y, carry_in,
//        out_valid/out_ready, z, carry_out, overflow (SIGNED_OVERFLOW_EN).
module multicycle_chunk_adder
    import multicycle_chunk_adder_pkg::*;
#(
    parameter  int CHUNK_WIDTH = 8,
    parameter  int NUM_CHUNKS  = 4,
    localparam int TOTAL_WIDTH = CHUNK_WIDTH * NUM_CHUNKS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TOTAL_WIDTH-1:0] x,
    input  logic [TOTAL_WIDTH-1:0] y,
    input  logic                   carry_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TOTAL_WIDTH-1:0] z,
    output logic                   carry_out
`ifdef SIGNED_OVERFLOW_EN
    ,
    output logic                   overflow
`endif
);

    localparam int CNT_W = cnt_width(NUM_CHUNKS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [TOTAL_WIDTH-1:0] x_q;
    logic [TOTAL_WIDTH-1:0] y_q;
    logic [TOTAL_WIDTH-1:0] z_q;
    logic                   carry_q;
    logic                   cout_q;
    logic [CNT_W-1:0]       cnt_q;
    int unsigned            base;
    logic [CHUNK_WIDTH-1:0] a_chunk;
    logic [CHUNK_WIDTH-1:0] b_chunk;
    logic [CHUNK_WIDTH-1:0] sum_chunk;
    logic                   slice_cout;
    logic                   unused_gg;
    logic                   unused_gp;
    logic                   accept;
    logic                   last_chunk;

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign accept     = in_valid && in_ready;
    assign last_chunk = (cnt_q == LAST);
    assign z          = z_q;
    assign carry_out  = cout_q;

    assign base    = int'(cnt_q) * CHUNK_WIDTH;
    assign a_chunk = x_q[base +: CHUNK_WIDTH];
    assign b_chunk = y_q[base +: CHUNK_WIDTH];

    carry_lookahead_adder #(
        .WIDTH(CHUNK_WIDTH)
    ) u_cla (
        .a              (a_chunk),
        .b              (b_chunk),
        .cin            (carry_q),
        .sum            (sum_chunk),
        .cout           (slice_cout),
        .group_generate (unused_gg),
        .group_propagate(unused_gp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid)   state_d = ST_ADD;
            ST_ADD:  if (last_chunk) state_d = ST_DONE;
            ST_DONE: if (out_ready)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // carry_q holds carry_in on accept, then the slice carry of the
    // previous chunk for every following chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            x_q     <= x;
            y_q     <= y;
            carry_q <= carry_in;
            cnt_q   <= '0;
        end else if (state_q == ST_ADD) begin
            z_q[base +: CHUNK_WIDTH] <= sum_chunk;
            carry_q <= slice_cout;
            if (last_chunk) begin
                cout_q <= slice_cout;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef SIGNED_OVERFLOW_EN
    logic ovf_q;

    // Result sign is the final slice's top sum bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == ST_ADD && last_chunk) begin
            ovf_q <= (x_q[TOTAL_WIDTH-1] == y_q[TOTAL_WIDTH-1]) &&
                     (sum_chunk[CHUNK_WIDTH-1] != x_q[TOTAL_WIDTH-1]);
        end
    end

    assign overflow = ovf_q;
`endif

endmodule
